// File: rtl/contador_decrescente.sv
// rtl/contador_decrescente.sv - programmable down counter with terminal-count pulse
//
// Purpose:
//   Counts from a loaded or default value (MAX) down toward 0.
//   It moves one step on each enabled clock while COUNTING.
//   The terminal-count pulse (tc) and the zero flag tell downstream
//   sequencing FSMs that a countdown has finished.
//
// Optional build macro:
//   CONTADOR_DECRESCENTE_AUTO_RELOAD_EN
//     defined   : free-running; the terminal event reloads MAX and stays COUNTING
//     undefined : one-shot; the terminal event parks in DONE with S == 0
//
// Ports:
//   clock       in   system clock, rising-edge active
//   reset       in   synchronous active-high reset
//   start       in   begin counting (from S in IDLE, from MAX in DONE)
//   enable      in   decrement qualifier while COUNTING
//   load        in   load load_value (saturated to MAX) and enter COUNTING
//   load_value  in   [WIDTH-1:0] value for load
//   S           out  [WIDTH-1:0] current count (registered)
//   zero        out  S == 0 (combinational)
//   tc          out  one-cycle terminal-count pulse (registered)
//   busy        out  high while COUNTING (registered)

module contador_decrescente #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] S,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_s;
  logic             r_tc;
  logic             r_busy;

  logic [WIDTH-1:0] w_load_sat;
  logic             w_terminal;

  // Keep S within 0..MAX no matter what value a load asks for.
  assign w_load_sat = (load_value > MAX_V) ? MAX_V : load_value;

  // The terminal event is an enabled step taken while the count already sits at 0.
  assign w_terminal = (r_state == ST_COUNTING) && enable && (r_s == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s     <= MAX_V;
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // tc is a single-cycle pulse; the terminal branch below re-asserts it.
      r_tc <= 1'b0;

      if (load) begin
        r_s     <= w_load_sat;
        r_state <= ST_COUNTING;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_COUNTING;
              r_busy  <= 1'b1;
            end
          end

          ST_COUNTING: begin
            // start is deliberately ignored here: the running count continues.
            if (w_terminal) begin
              r_tc <= 1'b1;
`ifdef CONTADOR_DECRESCENTE_AUTO_RELOAD_EN
              r_s     <= MAX_V;
              r_state <= ST_COUNTING;
              r_busy  <= 1'b1;
`else
              r_s     <= '0;
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
`endif
            end else if (enable) begin
              r_s <= r_s - WIDTH'(1);
            end
          end

          ST_DONE: begin
            if (start) begin
              r_s     <= MAX_V;
              r_state <= ST_COUNTING;
              r_busy  <= 1'b1;
            end
          end

          default: begin
            r_s     <= MAX_V;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign S    = r_s;
  assign zero = (r_s == '0);
  assign tc   = r_tc;
  assign busy = r_busy;

endmodule

// File: tb/tb_contador_decrescente.sv
// tb/tb_contador_decrescente.sv - scoreboard bench for contador_decrescente

module tb_contador_decrescente;

  localparam int WIDTH = 3;
  localparam int MAX   = 4;

`ifdef CONTADOR_DECRESCENTE_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  // Outputs right after a terminal event, per build.
  localparam logic [2:0] TERM_S    = AR ? 3'd4 : 3'd0;
  localparam logic       TERM_BUSY = AR ? 1'b1 : 1'b0;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             enable = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [WIDTH-1:0] S;
  logic             zero;
  logic             tc;
  logic             busy;

  contador_decrescente #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .S          (S),
    .zero       (zero),
    .tc         (tc),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         tgt;
    string      name;
    logic [2:0] s;
    logic       z;
    logic       t;
    logic       b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clock) cyc++;

  // Monitor: the outputs after edge N are checked against the entry targeted at N.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.tgt == cyc && {S, zero, tc, busy} === {e.s, e.z, e.t, e.b}) begin
        passes++;
      end else begin
        $display("FAIL %s: got S=%0d zero=%0b tc=%0b busy=%0b, expected S=%0d zero=%0b tc=%0b busy=%0b",
                 e.name, S, zero, tc, busy, e.s, e.z, e.t, e.b);
      end
    end
  end

  // Drive the inputs for the next edge and queue what the outputs must be after it.
  task automatic step(input string nm, input logic r, input logic st, input logic en,
                      input logic ld, input logic [2:0] lv,
                      input logic [2:0] es, input logic et, input logic eb);
    exp_t x;
    @(posedge clock);
    #1;
    reset      = r;
    start      = st;
    enable     = en;
    load       = ld;
    load_value = lv;
    x.tgt  = cyc + 1;
    x.name = nm;
    x.s    = es;
    x.z    = (es == 3'd0);
    x.t    = et;
    x.b    = eb;
    q.push_back(x);
  endtask

  initial begin
    // A: reset, enable ignored in IDLE, start, full countdown to the terminal event
    step("rst0",        1, 0, 0, 0, 0, 3'd4, 0, 0);
    step("rst1",        1, 0, 0, 0, 0, 3'd4, 0, 0);
    step("idle_en",     0, 0, 1, 0, 0, 3'd4, 0, 0);
    step("start",       0, 1, 0, 0, 0, 3'd4, 0, 1);
    step("cnt3",        0, 0, 1, 0, 0, 3'd3, 0, 1);
    step("cnt2",        0, 0, 1, 0, 0, 3'd2, 0, 1);
    step("cnt1",        0, 0, 1, 0, 0, 3'd1, 0, 1);
    step("cnt0",        0, 0, 1, 0, 0, 3'd0, 0, 1);
    step("term_a",      0, 0, 1, 0, 0, TERM_S, 1, TERM_BUSY);
`ifdef CONTADOR_DECRESCENTE_AUTO_RELOAD_EN
    step("wrap3",       0, 0, 1, 0, 0, 3'd3, 0, 1);
    step("wrap2",       0, 0, 1, 0, 0, 3'd2, 0, 1);
    step("wrap1",       0, 0, 1, 0, 0, 3'd1, 0, 1);
    step("wrap0",       0, 0, 1, 0, 0, 3'd0, 0, 1);
    step("wrap_term",   0, 0, 1, 0, 0, 3'd4, 1, 1);
    step("wrap_after",  0, 0, 1, 0, 0, 3'd3, 0, 1);
`else
    step("done_en",     0, 0, 1, 0, 0, 3'd0, 0, 0);
    step("done_start",  0, 1, 0, 0, 0, 3'd4, 0, 1);
    step("ld0_en",      0, 0, 1, 1, 0, 3'd0, 0, 1);
    step("ld0_term",    0, 0, 1, 0, 0, 3'd0, 1, 0);
    step("done_hold",   0, 0, 0, 0, 0, 3'd0, 0, 0);
`endif

    // B: enable toggling, start while counting, load beats start
    step("rst_b",       1, 0, 0, 0, 0, 3'd4, 0, 0);
    step("start_b",     0, 1, 0, 0, 0, 3'd4, 0, 1);
    step("tog_en1",     0, 0, 1, 0, 0, 3'd3, 0, 1);
    step("tog_en0a",    0, 0, 0, 0, 0, 3'd3, 0, 1);
    step("tog_en0b",    0, 0, 0, 0, 0, 3'd3, 0, 1);
    step("tog_en1b",    0, 0, 1, 0, 0, 3'd2, 0, 1);
    step("start_cnt",   0, 1, 0, 0, 0, 3'd2, 0, 1);
    step("ld_vs_start", 0, 1, 0, 1, 1, 3'd1, 0, 1);
    step("b_cnt0",      0, 0, 1, 0, 0, 3'd0, 0, 1);
    step("term_b",      0, 0, 1, 0, 0, TERM_S, 1, TERM_BUSY);
    step("after_b",     0, 0, 0, 0, 0, TERM_S, 0, TERM_BUSY);

    // C: load saturation, load of an in-range value, countdown to tc
    step("rst_c",       1, 0, 0, 0, 0, 3'd4, 0, 0);
    step("ld7_sat",     0, 0, 0, 1, 7, 3'd4, 0, 1);
    step("ld5_sat",     0, 0, 0, 1, 5, 3'd4, 0, 1);
    step("ld2",         0, 0, 1, 1, 2, 3'd2, 0, 1);
    step("c_cnt1",      0, 0, 1, 0, 0, 3'd1, 0, 1);
    step("c_cnt0",      0, 0, 1, 0, 0, 3'd0, 0, 1);
    step("term_c",      0, 0, 1, 0, 0, TERM_S, 1, TERM_BUSY);
    step("after_c",     0, 0, 0, 0, 0, TERM_S, 0, TERM_BUSY);

    // D: reset mid-count aborts with no tc; enable alone stays idle
    step("rst_d",       1, 0, 0, 0, 0, 3'd4, 0, 0);
    step("start_d",     0, 1, 0, 0, 0, 3'd4, 0, 1);
    step("d_cnt3",      0, 0, 1, 0, 0, 3'd3, 0, 1);
    step("rst_mid",     1, 1, 1, 1, 2, 3'd4, 0, 0);
    step("d_idle_en1",  0, 0, 1, 0, 0, 3'd4, 0, 0);
    step("d_idle_en2",  0, 0, 1, 0, 0, 3'd4, 0, 0);
    step("d_start",     0, 1, 1, 0, 0, 3'd4, 0, 1);
    step("d_cnt3b",     0, 0, 1, 0, 0, 3'd3, 0, 1);
    step("d_ld4",       0, 0, 1, 1, 4, 3'd4, 0, 1);
    step("d_cnt3c",     0, 0, 1, 0, 0, 3'd3, 0, 1);
    step("d_idle_out",  0, 0, 0, 0, 0, 3'd3, 0, 1);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
